// File: rtl/time_digit_regs_pkg.sv
// Shared definitions for the time/date display register bank:
// register address map, BCD byte type and commit state encoding.
package time_digit_regs_pkg;

  localparam logic [3:0] ADDR_DAY    = 4'd0;
  localparam logic [3:0] ADDR_MONTH  = 4'd1;
  localparam logic [3:0] ADDR_YEAR   = 4'd2;
  localparam logic [3:0] ADDR_HOUR   = 4'd3;
  localparam logic [3:0] ADDR_MIN    = 4'd4;
  localparam logic [3:0] ADDR_SEC    = 4'd5;
  localparam logic [3:0] ADDR_SW_HR  = 4'd6;
  localparam logic [3:0] ADDR_SW_MIN = 4'd7;
  localparam logic [3:0] ADDR_SW_SEC = 4'd8;
  localparam logic [3:0] ADDR_COMMIT = 4'd15;

  localparam int NUM_REGS = 9;

  typedef logic [7:0] bcd_byte_t;

  typedef enum logic {
    ST_IDLE,
    ST_PEND
  } commit_state_t;

  function automatic logic bcd_ok(input bcd_byte_t b);
    return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9);
  endfunction

endpackage

// File: rtl/time_digit_regs_bcd_hour12.sv
// bcd_hour12: combinational 24-hour BCD to 12-hour BCD conversion with pm flag.
// Inputs outside 00..23 give unspecified results.
module bcd_hour12
  import time_digit_regs_pkg::*;
(
  input  bcd_byte_t hour_in,
  output bcd_byte_t hour_out,
  output logic      pm
);

  logic [6:0] bin;
  logic [6:0] adj;

  // Go through binary so the tens borrow (e.g. 21 -> 09) falls out naturally.
  always_comb begin
    bin = {hour_in[7:4], 3'b000} + {2'b00, hour_in[7:4], 1'b0} + {3'b000, hour_in[3:0]};
    pm  = (bin >= 7'd12);
    if (bin == 7'd0) begin
      adj = 7'd12;
    end else if (bin > 7'd12) begin
      adj = bin - 7'd12;
    end else begin
      adj = bin;
    end
    if (adj >= 7'd10) begin
      hour_out = {4'd1, 4'(adj - 7'd10)};
    end else begin
      hour_out = {4'd0, adj[3:0]};
    end
  end

endmodule

// File: rtl/time_digit_regs.sv
// time_digit_regs: shadow registers for BCD date/time/stopwatch bytes, committed
// atomically to the display digits on a frame tick. Define HOUR12_EN for 12-hour display.
module time_digit_regs
  import time_digit_regs_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [3:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic       frame_tick,
  output logic [3:0] dig0,
  output logic [3:0] dig1,
  output logic [3:0] dig2,
  output logic [3:0] dig3,
  output logic [3:0] dig4,
  output logic [3:0] dig5,
  output logic [3:0] dig6,
  output logic [3:0] dig7,
  output logic [3:0] dig8,
  output logic [3:0] dig9,
  output logic [3:0] dig10,
  output logic [3:0] dig11,
  output logic [3:0] dig12,
  output logic [3:0] dig13,
  output logic [3:0] dig14,
  output logic [3:0] dig15,
  output logic [3:0] dig16,
  output logic [3:0] dig17,
  output logic       pm,
  output logic       err,
  output logic       commit_busy
);

  commit_state_t state, next_state;
  bcd_byte_t     shadow [NUM_REGS];
  bcd_byte_t     disp   [NUM_REGS];
  bcd_byte_t     hour_disp;
  logic          pm_disp;
  logic          do_commit;
  logic          accept;
  logic          is_commit;
  logic          write_ok;

  assign accept    = wr_valid && wr_ready;
  assign is_commit = (wr_addr == ADDR_COMMIT);
  assign write_ok  = (wr_addr <= ADDR_SW_SEC) && bcd_ok(wr_data);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // In IDLE the port is always ready, so wr_valid alone means the COMMIT is accepted.
  always_comb begin
    next_state  = state;
    wr_ready    = 1'b0;
    commit_busy = 1'b0;
    do_commit   = 1'b0;
    case (state)
      ST_IDLE: begin
        wr_ready = 1'b1;
        if (wr_valid && is_commit) begin
          next_state = ST_PEND;
        end
      end
      ST_PEND: begin
        commit_busy = 1'b1;
        if (frame_tick) begin
          do_commit  = 1'b1;
          next_state = ST_IDLE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        shadow[i] <= '0;
      end
      err <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (accept && write_ok && (wr_addr == 4'(i))) begin
          shadow[i] <= wr_data;
        end
      end
      err <= accept && !write_ok && !is_commit;
    end
  end

`ifdef HOUR12_EN
  bcd_hour12 u_hour12 (
    .hour_in  (shadow[ADDR_HOUR]),
    .hour_out (hour_disp),
    .pm       (pm_disp)
  );
`else
  assign hour_disp = shadow[ADDR_HOUR];
  assign pm_disp   = 1'b0;
`endif

  // The hour slot takes the (possibly converted) value; all others copy straight through.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        disp[i] <= '0;
      end
      pm <= 1'b0;
    end else if (do_commit) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        disp[i] <= (i == int'(ADDR_HOUR)) ? hour_disp : shadow[i];
      end
      pm <= pm_disp;
    end
  end

  assign dig0  = disp[0][7:4];
  assign dig1  = disp[0][3:0];
  assign dig2  = disp[1][7:4];
  assign dig3  = disp[1][3:0];
  assign dig4  = disp[2][7:4];
  assign dig5  = disp[2][3:0];
  assign dig6  = disp[3][7:4];
  assign dig7  = disp[3][3:0];
  assign dig8  = disp[4][7:4];
  assign dig9  = disp[4][3:0];
  assign dig10 = disp[5][7:4];
  assign dig11 = disp[5][3:0];
  assign dig12 = disp[6][7:4];
  assign dig13 = disp[6][3:0];
  assign dig14 = disp[7][7:4];
  assign dig15 = disp[7][3:0];
  assign dig16 = disp[8][7:4];
  assign dig17 = disp[8][3:0];

endmodule

// File: tb/tb_time_digit_regs.sv
// Scoreboard bench for time_digit_regs: stimulus pushes expected commits/err pulses,
// a negedge monitor pops and compares them. Expectations follow HOUR12_EN if defined.
module tb_time_digit_regs;
  import time_digit_regs_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       wr_valid = 1'b0;
  logic [3:0] wr_addr = 4'd0;
  logic [7:0] wr_data = 8'd0;
  logic       frame_tick = 1'b0;
  logic       wr_ready, pm, err, commit_busy;
  logic [3:0] dig0, dig1, dig2, dig3, dig4, dig5, dig6, dig7, dig8;
  logic [3:0] dig9, dig10, dig11, dig12, dig13, dig14, dig15, dig16, dig17;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [7:0]  exp_shadow [NUM_REGS];
  logic [72:0] exp_disp;
  logic [72:0] commit_q [$];
  int          err_q [$];
  bit          pending;

  logic [72:0] act_snap;
  logic [72:0] last_snap = '0;
  logic        prev_busy = 1'b0;

  // Hand-computed hour vectors: input, displayed byte, pm.
  logic [7:0] hr_in  [6] = '{8'h00, 8'h12, 8'h13, 8'h23, 8'h21, 8'h20};
`ifdef HOUR12_EN
  logic [7:0] hr_out [6] = '{8'h12, 8'h12, 8'h01, 8'h11, 8'h09, 8'h08};
  logic       hr_pm  [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
`else
  logic [7:0] hr_out [6] = '{8'h00, 8'h12, 8'h13, 8'h23, 8'h21, 8'h20};
  logic       hr_pm  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  time_digit_regs dut (
    .clk(clk), .reset(reset),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .frame_tick(frame_tick),
    .dig0(dig0), .dig1(dig1), .dig2(dig2), .dig3(dig3), .dig4(dig4), .dig5(dig5),
    .dig6(dig6), .dig7(dig7), .dig8(dig8), .dig9(dig9), .dig10(dig10), .dig11(dig11),
    .dig12(dig12), .dig13(dig13), .dig14(dig14), .dig15(dig15), .dig16(dig16), .dig17(dig17),
    .pm(pm), .err(err), .commit_busy(commit_busy)
  );

  assign act_snap = {pm, dig0, dig1, dig2, dig3, dig4, dig5, dig6, dig7, dig8,
                     dig9, dig10, dig11, dig12, dig13, dig14, dig15, dig16, dig17};

  task automatic check_output(input string name, input logic [72:0] act, input logic [72:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [8:0] model_hour(input logic [7:0] h);
    int v;
    int o;
    logic p;
    v = int'(h[7:4]) * 10 + int'(h[3:0]);
`ifdef HOUR12_EN
    if (v == 0) begin o = 12; p = 1'b0; end
    else if (v < 12) begin o = v; p = 1'b0; end
    else if (v == 12) begin o = 12; p = 1'b1; end
    else begin o = v - 12; p = 1'b1; end
`else
    o = v;
    p = 1'b0;
`endif
    return {p, 4'(o / 10), 4'(o % 10)};
  endfunction

  function automatic logic [72:0] model_snap();
    logic [72:0] s;
    logic [8:0]  h;
    s = '0;
    for (int i = 0; i < NUM_REGS; i++) s[71-8*i -: 8] = exp_shadow[i];
    h = model_hour(exp_shadow[3]);
    s[47 -: 8] = h[7:0];
    s[72] = h[8];
    return s;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_REGS; i++) exp_shadow[i] = 8'h00;
    exp_disp = '0;
    pending = 1'b0;
    commit_q.delete();
    err_q.delete();
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Holds the request until the handshake completes, then updates the model.
  task automatic apply_stimulus(input logic [3:0] addr, input logic [7:0] data);
    bit taken;
    int budget;
    taken = 1'b0;
    budget = 0;
    wr_valid = 1'b1;
    wr_addr = addr;
    wr_data = data;
    while (!taken && budget < 100) begin
      @(negedge clk);
      taken = wr_ready;
      @(posedge clk);
      #1;
      budget++;
    end
    wr_valid = 1'b0;
    if (!taken) begin
      failures++;
      $display("[TB] FAIL write_timeout addr=%0d actual=not_accepted required=accepted", addr);
      return;
    end
    if (addr == ADDR_COMMIT) pending = 1'b1;
    else if (addr <= ADDR_SW_SEC && data[7:4] <= 4'd9 && data[3:0] <= 4'd9) exp_shadow[addr] = data;
    else err_q.push_back(cyc);
  endtask

  task automatic apply_tick();
    if (pending) begin
      exp_disp = model_snap();
      commit_q.push_back(exp_disp);
      pending = 1'b0;
    end
    frame_tick = 1'b1;
    @(posedge clk);
    #1;
    frame_tick = 1'b0;
  endtask

  task automatic apply_commit_with_tick();
    wr_valid = 1'b1;
    wr_addr = ADDR_COMMIT;
    frame_tick = 1'b1;
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
    frame_tick = 1'b0;
    pending = 1'b1;
  endtask

  // Monitor: commit edges pop expected snapshots; otherwise the display must hold.
  always @(negedge clk) begin
    if (!reset) begin
      prev_busy = 1'b0;
      last_snap = act_snap;
    end else begin
      if (prev_busy && !commit_busy) begin
        if (commit_q.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_commit actual=%h required=none", act_snap);
        end else begin
          check_output("commit", act_snap, commit_q.pop_front());
        end
      end else begin
        check_output("display_stable", act_snap, last_snap);
      end
      if (err) begin
        if (err_q.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_err actual=1 required=0 cycle=%0d", cyc);
        end else begin
          check_output("err_cycle", 73'(cyc), 73'(err_q.pop_front()));
        end
      end else if (err_q.size() > 0 && err_q[0] <= cyc) begin
        checks++;
        failures++;
        $display("[TB] FAIL missing_err actual=0 required=1 cycle=%0d", err_q.pop_front());
      end
      prev_busy = commit_busy;
      last_snap = act_snap;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_output("reset_digits", act_snap, '0);
    check_output("reset_flags", {wr_ready, commit_busy, err}, 73'b100);
    @(posedge clk);
    #1;
    reset = 1'b1;
    wait_cycles(2);

    // Seconds byte then COMMIT; port must stall until the tick edge.
    apply_stimulus(ADDR_SEC, 8'h59);
    apply_stimulus(ADDR_COMMIT, 8'hFF);
    @(negedge clk);
    check_output("pend_flags", {wr_ready, commit_busy}, 73'b01);
    @(posedge clk);
    #1;
    apply_tick();
    @(negedge clk);
    check_output("sec_digits", {dig10, dig11}, 73'h59);
    check_output("idle_flags", {wr_ready, commit_busy}, 73'b10);
    @(posedge clk);
    #1;

    // Rejected writes: bad nibble, reserved address, bad tens nibble.
    apply_stimulus(ADDR_MIN, 8'h3A);
    apply_stimulus(4'd10, 8'h11);
    apply_stimulus(ADDR_DAY, 8'hA1);
    apply_stimulus(ADDR_COMMIT, 8'h00);
    apply_tick();
    wait_cycles(1);
    check_output("min_untouched", {dig8, dig9}, 73'h00);

    // Back-to-back fill of the remaining registers.
    apply_stimulus(ADDR_DAY, 8'h31);
    apply_stimulus(ADDR_MONTH, 8'h12);
    apply_stimulus(ADDR_YEAR, 8'h24);
    apply_stimulus(ADDR_MIN, 8'h07);
    apply_stimulus(ADDR_SW_HR, 8'h01);
    apply_stimulus(ADDR_SW_MIN, 8'h45);
    apply_stimulus(ADDR_SW_SEC, 8'h59);

    for (int k = 0; k < 6; k++) begin
      apply_stimulus(ADDR_HOUR, hr_in[k]);
      apply_stimulus(ADDR_COMMIT, 8'h00);
      wait_cycles(1);
      apply_tick();
      @(negedge clk);
      check_output($sformatf("hour_%h", hr_in[k]), {pm, dig6, dig7}, {hr_pm[k], hr_out[k]});
      @(posedge clk);
      #1;
    end

    // Shadow writes without COMMIT are invisible across ticks.
    apply_stimulus(ADDR_MIN, 8'h33);
    repeat (3) apply_tick();
    wait_cycles(1);
    check_output("no_commit_hold", act_snap, exp_disp);

    // COMMIT coincident with a tick waits for the following tick.
    apply_commit_with_tick();
    wait_cycles(2);
    check_output("coincident_hold", act_snap, exp_disp);
    check_output("coincident_busy", commit_busy, 73'b1);
    apply_tick();
    wait_cycles(1);
    check_output("min_33", {dig8, dig9}, 73'h33);

    // Write held off during PEND is taken only after the tick.
    apply_stimulus(ADDR_COMMIT, 8'h00);
    fork
      apply_stimulus(ADDR_HOUR, 8'h10);
      begin
        wait_cycles(3);
        apply_tick();
      end
    join
    wait_cycles(1);
    check_output("hour_still_old", {pm, dig6, dig7}, {hr_pm[5], hr_out[5]});
    apply_stimulus(ADDR_COMMIT, 8'h00);
    apply_tick();
    wait_cycles(1);
    check_output("hour_10", {pm, dig6, dig7}, 73'h010);

    // Asynchronous reset in the middle of a pending commit.
    apply_stimulus(ADDR_SEC, 8'h11);
    apply_stimulus(ADDR_COMMIT, 8'h00);
    #2;
    reset = 1'b0;
    #1;
    check_output("async_reset_digits", act_snap, '0);
    check_output("async_reset_flags", {wr_ready, commit_busy, err}, 73'b100);
    model_reset();
    wait_cycles(2);
    reset = 1'b1;
    wait_cycles(1);
    apply_tick();
    wait_cycles(2);
    check_output("post_reset_tick", act_snap, '0);

    wait_cycles(3);
    check_output("queues_drained", 73'(commit_q.size() + err_q.size()), 73'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/time_digit_regs.md
# time_digit_regs

Holding register bank that sits directly upstream of the on-screen text generator. It accepts BCD date, time and stopwatch bytes from the RTC controller over a valid/ready write port and keeps them in shadow registers. At the next frame tick it commits them atomically to the eighteen display digits `dig0`..`dig17`. This prevents a frame from showing a mix of old and new values, such as a torn 23:59:59 → 00:00:00 rollover.

## Interface
Parameters: none.

Ports:
- `clk` in 1: system/pixel clock; single clock domain.
- `reset` in 1: asynchronous, active-low reset.
- `wr_valid` in 1: write request from the RTC controller.
- `wr_ready` out 1: the block can accept a write.
- `wr_addr` in 4: register select (see Operation).
- `wr_data` in 8: packed BCD byte, tens in [7:4], units in [3:0].
- `frame_tick` in 1: one-cycle pulse at the start of vertical blank, from the sync generator.
- `dig0`..`dig17` out 4 each: committed BCD digits to the text generator.
- `pm` out 1: PM indicator for the AM/PM text rows.
- `err` out 1: one-cycle pulse when a write is rejected.
- `commit_busy` out 1: a commit is pending.

## Operation
Address map. Each register feeds a pair of digits (tens, units):
- 0 day → `dig0`/`dig1`
- 1 month → `dig2`/`dig3`
- 2 year (two low digits) → `dig4`/`dig5`
- 3 hour → `dig6`/`dig7`
- 4 min → `dig8`/`dig9`
- 5 sec → `dig10`/`dig11`
- 6 stopwatch hours → `dig12`/`dig13`
- 7 stopwatch minutes → `dig14`/`dig15`
- 8 stopwatch seconds → `dig16`/`dig17`
- 15 COMMIT; `wr_data` is ignored.

Write acceptance:
- A write is accepted when `wr_valid && wr_ready`.
- Addresses 0–8 with both nibbles ≤ 9 update the shadow register.
- A rejected write is still consumed (handshake completes), but the shadow is left unchanged and `err` pulses. Rejected writes are:
  - a write to address 0–8 with either nibble > 9;
  - a write to any of addresses 9–14.

Commit state machine:
- IDLE: `wr_ready`=1, `commit_busy`=0.
  - An accepted COMMIT moves the block to PEND.
- PEND: `wr_ready`=0, `commit_busy`=1.
  - On `frame_tick`=1, all shadow registers are copied to the display registers in one edge, then the block returns to IDLE.

Hour handling: the hour is converted at commit time only (see Configuration). The shadow always holds the raw 24-hour value.

## Timing
- Reset values: all `dig*`=0, shadow=0, `pm`=0, `err`=0, `commit_busy`=0, `wr_ready`=1, state IDLE.
- Write latency: the shadow updates at the edge where the handshake completes. `err` is asserted for the cycle after that edge.
- Commit latency: `dig*` and `pm` change at the edge ending the cycle in which `frame_tick`=1 in PEND. In the same edge `commit_busy` drops and `wr_ready` rises.
- COMMIT accepted in the same cycle as `frame_tick`: that tick is not used; the commit waits for the next tick.
- `frame_tick` in IDLE: no effect.
- Back-to-back writes are sustained at one per cycle in IDLE.
- `wr_valid` while `wr_ready`=0: held off; the master must keep `wr_valid`, `wr_addr` and `wr_data` stable until accepted.
- Reset asserted mid-PEND: the pending commit is discarded, and outputs immediately take their reset values (asynchronous).
- Display outputs are registered and glitch-free; they change only on commit edges.

## Configuration
`HOUR12_EN`:
- Defined: at commit, a 24-hour BCD hour h is displayed in 12-hour form.
  - h=00 → 12, `pm`=0
  - h=01–11 → unchanged, `pm`=0
  - h=12 → 12, `pm`=1
  - h=13–23 → h−12 in BCD, `pm`=1
  - The conversion must produce BCD directly (for example, 21→09, 20→08, 13→01).
- Undefined: `dig6`/`dig7` carry the raw 24-hour value and `pm` is constant 0.

The macro does not affect the stopwatch registers.

## Structure
- Shared package: register address constants (`ADDR_DAY`..`ADDR_SW_SEC`, `ADDR_COMMIT`=15), the BCD byte typedef, and the commit state enum.
- One natural sub-module, `bcd_hour12`: combinational conversion from 8-bit BCD hour to 8-bit BCD hour plus a pm flag. It is instantiated only under `HOUR12_EN`.

## Test plan
- Reset, then write addr 5 = 0x59, COMMIT, one `frame_tick` → `dig10`=5, `dig11`=9 after the tick edge; all other digits 0; `wr_ready` is low from COMMIT acceptance to the tick edge.
- Write addr 4 = 0x3A → `err` pulses one cycle; after COMMIT and a tick, `dig8`/`dig9` remain 0.
- With `HOUR12_EN`: hour 0x00, 0x12, 0x13, 0x23 each committed → displays 12/AM, 12/PM, 01/PM, 11/PM. Without it, 0x23 → `dig6`=2, `dig7`=3, `pm`=0.
- Shadow writes without COMMIT followed by 3 ticks → `dig*` unchanged. COMMIT accepted in the same cycle as a tick → no update until the next tick.
- Commit pending, then `wr_valid` with addr 3 = 0x10 → not accepted until after the tick. Once accepted, it is displayed only after a second COMMIT and tick.
- Reset asserted while PEND → `dig*`=0 and `wr_ready`=1 after release; a subsequent tick causes no update.
